dmem_ctrl: RTL
==============

// Module: dmem_ctrl
// PURPOSE
//  Parametrised byte-addressed, little-endian data memory with valid/ready request and response handshakes.
//  Supports word/half/byte stores and signed/unsigned byte and half loads.
//  Access latency is configurable; memory is cleared after reset.
//  Sits between the CPU MEM stage and the backing store; successor to the fixed combinational-read data memory.
// PARAMETERS
//  DEPTH          2048  memory size in bytes; power of 2, multiple of 4
//  ADDR_W         11    byte address width; equals clog2(DEPTH)
//  LATENCY        1     cycles from request accept to resp_valid; >=1
//  CLEAR_ON_RESET 1     1: sweep all bytes to 0 after rst; 0: contents kept
// PORTS
//  clk         in   1       clock; all state updates on rising edge
//  rst         in   1       reset, synchronous, active-high
//  req_valid   in   1       request present
//  req_ready   out  1       controller accepts the request this cycle
//  req_we      in   1       1 = store, 0 = load
//  req_size    in   2       00 word, 01 byte, 10 half, 11 illegal
//  req_signed  in   1       load sign-extend (byte/half only)
//  req_addr    in   ADDR_W  byte address
//  req_wdata   in   32      store data, LSB-aligned
//  resp_valid  out  1       response present
//  resp_ready  in   1       consumer takes the response
//  resp_rdata  out  32      load data, extended; 0 for stores/errors
//  resp_err    out  1       access rejected (illegal size, or misaligned when trapping)
//  busy        out  1       clear sweep in progress
// BEHAVIOUR
//  Reset values: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, busy=CLEAR_ON_RESET.
//  FSM states: CLEAR, IDLE, WAIT, RESP.
//  rst -> CLEAR if CLEAR_ON_RESET, else IDLE.
//   An in-flight access is dropped; no write commits; no response is issued.
//  CLEAR: zeroes 4 bytes per cycle from addr 0.
//   Lasts DEPTH/4 cycles, then goes to IDLE; busy=1 throughout; req_ready=0.
//  IDLE: req_ready=1; on req_valid&&req_ready, latch all req_* fields.
//   Then go to RESP if LATENCY==1, else to WAIT with counter=LATENCY-1.
//  WAIT: counter decrements each cycle; at 1, go to RESP; req_ready=0.
//  Entry into RESP: resp_valid, resp_rdata and resp_err are registered.
//   A store commits to the array on the same edge.
//   resp_valid therefore rises exactly LATENCY edges after the accept edge.
//  RESP: outputs are held stable until resp_valid&&resp_ready, then go to IDLE.
//   The next request can be accepted the cycle after the handshake; max throughput is 1 per LATENCY+1 cycles.
//  Byte lanes: lane i maps to byte (addr+i) mod DEPTH; the top address wraps to 0.
//  Loads: word = {b3,b2,b1,b0}.
//   byte = {24{s&b0[7]}, b0}.
//   half = {16{s&b1[7]}, b1, b0}, where s = req_signed.
//  Stores: byte writes wdata[7:0]; half writes [15:0]; word writes [31:0]; other bytes are untouched.
//  size 11: resp_err=1, rdata=0, no write; handshake completes normally.
//  Misaligned access: half with addr[0]!=0, or word with addr[1:0]!=0; handling is set by macro below.
//  A load directly after a store to the same address returns the new data.
// CONFIGURATION
//  DMEM_ALIGN_TRAP_EN defined: a misaligned access gives resp_err=1, resp_rdata=0 and no array write.
//  DMEM_ALIGN_TRAP_EN undefined: a misaligned access proceeds byte-wise with address wrap; resp_err=0.
// TESTING
//  1. LATENCY=1: store word 0x12345678 @0x010, then load word @0x010.
//     -> rdata=0x12345678, resp_valid 1 edge after accept.
//  2. Store byte 0x80 @0x021; load signed byte @0x021 -> 0xFFFFFF80.
//     Load unsigned byte -> 0x00000080; byte @0x020 unchanged.
//  3. Store half 0x8001 @0x030; signed half load -> 0xFFFF8001; unsigned -> 0x00008001.
//  4. Word store 0xAABBCCDD @DEPTH-2.
//     Trap undefined -> bytes DEPTH-2..1 = DD,CC,BB,AA, err=0.
//     Trap defined -> err=1, memory unchanged.
//  5. LATENCY=3: assert rst in WAIT of a store -> no write, resp_valid=0.
//     busy=1 for DEPTH/4 cycles; after that, load of the target address returns 0.
//  6. Hold resp_ready=0 for 5 cycles in RESP -> resp_* stable, req_ready=0.
//     Request accepted the cycle after the handshake.

Source files
------------

// File: rtl/dmem_if.sv
// Request/response bus between the CPU MEM stage and dmem_ctrl.
// The master drives requests and takes responses; the slave is the memory controller.
interface dmem_if #(
    parameter int ADDR_W = 11
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed little-endian data memory with valid/ready request
// and response handshakes, configurable access latency and a post-reset clear sweep.
// Optional feature macro: DMEM_ALIGN_TRAP_EN
//   defined   -> misaligned half/word accesses are rejected with resp_err=1
//   undefined -> misaligned accesses proceed byte-wise with address wrap
module dmem_ctrl #(
    parameter int DEPTH          = 2048,
    parameter int ADDR_W         = 11,
    parameter int LATENCY        = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic    clk,
    input  logic    rst,
    dmem_if.slave   bus,
    output logic    busy
);

    localparam int WORDS = DEPTH / 4;
    localparam int CW    = (ADDR_W > 2) ? ADDR_W - 2 : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Byte lanes enabled by a store of the given size (size 11 writes nothing).
    function automatic logic [3:0] lane_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b1111;
            2'b01:   m = 4'b0001;
            2'b10:   m = 4'b0011;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Extend the raw little-endian lane bytes to a 32-bit load result.
    function automatic logic [31:0] load_extend(input logic [1:0] size,
                                                input logic sgn,
                                                input logic [31:0] raw);
        logic [31:0] d;
        case (size)
            2'b00:   d = raw;
            2'b01:   d = {{24{sgn & raw[7]}}, raw[7:0]};
            2'b10:   d = {{16{sgn & raw[15]}}, raw[15:0]};
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

`ifdef DMEM_ALIGN_TRAP_EN
    // Half needs addr[0]==0, word needs addr[1:0]==0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        case (size)
            2'b00:   mis = (lo != 2'b00);
            2'b10:   mis = lo[0];
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction
`endif

    logic [7:0]        mem_r [DEPTH];

    state_t            state_r;
    logic [CW-1:0]     clr_idx_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              we_r;
    logic [1:0]        size_r;
    logic              signed_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;

    logic              take_s;
    logic              enter_resp_s;
    logic              src_we_s;
    logic [1:0]        src_size_s;
    logic              src_signed_s;
    logic [ADDR_W-1:0] src_addr_s;
    logic [31:0]       src_wdata_s;
    logic [ADDR_W-1:0] lane_addr_s [4];
    logic [31:0]       raw_s;
    logic              err_s;
    logic [31:0]       rdata_s;
    logic [3:0]        wen_s;

    // Pick the access being resolved: live request when entering RESP straight
    // from IDLE (single-cycle latency), otherwise the latched request.
    always_comb begin
        take_s = (state_r == ST_IDLE) && bus.req_valid && bus.req_ready;
        if (state_r == ST_IDLE) begin
            src_we_s     = bus.req_we;
            src_size_s   = bus.req_size;
            src_signed_s = bus.req_signed;
            src_addr_s   = bus.req_addr;
            src_wdata_s  = bus.req_wdata;
        end else begin
            src_we_s     = we_r;
            src_size_s   = size_r;
            src_signed_s = signed_r;
            src_addr_s   = addr_r;
            src_wdata_s  = wdata_r;
        end
    end

    // Lane addressing with wrap, array read, error decode and store lane enables.
    always_comb begin
        raw_s = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            lane_addr_s[i]    = src_addr_s + ADDR_W'(i);
            raw_s[8*i +: 8]   = mem_r[lane_addr_s[i]];
        end
`ifdef DMEM_ALIGN_TRAP_EN
        err_s = (src_size_s == 2'b11) | is_misaligned(src_size_s, src_addr_s[1:0]);
`else
        err_s = (src_size_s == 2'b11);
`endif
        if (err_s || src_we_s) begin
            rdata_s = 32'h0000_0000;
        end else begin
            rdata_s = load_extend(src_size_s, src_signed_s, raw_s);
        end
        if (!err_s && src_we_s) begin
            wen_s = lane_mask(src_size_s);
        end else begin
            wen_s = 4'b0000;
        end
        // The edge that registers the response is also the store commit edge.
        enter_resp_s = !rst && ((take_s && (LATENCY == 1)) ||
                                ((state_r == ST_WAIT) && (cnt_r == CNT_W'(1))));
    end

    // Memory array: clear sweep writes one zero word per cycle; stores commit on RESP entry.
    always_ff @(posedge clk) begin
        if (!rst && (state_r == ST_CLEAR)) begin
            for (int i = 0; i < 4; i++) begin
                mem_r[{clr_idx_r, 2'b00} + ADDR_W'(i)] <= 8'h00;
            end
        end else if (enter_resp_s) begin
            for (int i = 0; i < 4; i++) begin
                if (wen_s[i]) begin
                    mem_r[lane_addr_s[i]] <= src_wdata_s[8*i +: 8];
                end
            end
        end
    end

    // Controller FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            busy           <= (CLEAR_ON_RESET != 0);
            clr_idx_r      <= '0;
            cnt_r          <= '0;
            we_r           <= 1'b0;
            size_r         <= 2'b00;
            signed_r       <= 1'b0;
            addr_r         <= '0;
            wdata_r        <= 32'h0000_0000;
            bus.req_ready  <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'h0000_0000;
            bus.resp_err   <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    clr_idx_r <= clr_idx_r + CW'(1);
                    if (clr_idx_r == CW'(WORDS - 1)) begin
                        state_r       <= ST_IDLE;
                        busy          <= 1'b0;
                        bus.req_ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    // Also raises ready on the first cycle after a reset without sweep.
                    bus.req_ready <= 1'b1;
                    if (take_s) begin
                        we_r          <= bus.req_we;
                        size_r        <= bus.req_size;
                        signed_r      <= bus.req_signed;
                        addr_r        <= bus.req_addr;
                        wdata_r       <= bus.req_wdata;
                        bus.req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            state_r        <= ST_RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_rdata <= rdata_s;
                            bus.resp_err   <= err_s;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == CNT_W'(1)) begin
                        state_r        <= ST_RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_rdata <= rdata_s;
                        bus.resp_err   <= err_s;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.resp_valid && bus.resp_ready) begin
                        state_r        <= ST_IDLE;
                        bus.resp_valid <= 1'b0;
                        bus.resp_rdata <= 32'h0000_0000;
                        bus.resp_err   <= 1'b0;
                        bus.req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_r        <= ST_IDLE;
                    busy           <= 1'b0;
                    bus.req_ready  <= 1'b0;
                    bus.resp_valid <= 1'b0;
                    bus.resp_rdata <= 32'h0000_0000;
                    bus.resp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule
